audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 128: entry count, power of two, minimum 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4: almost_full asserts when level >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty asserts when level <= AE_LEVEL.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1: synchronous discard of all stored samples.
REQ-008 SHALL have port wr_en, input, 1: write request.
REQ-009 SHALL have port din, input, WIDTH: write data.
REQ-010 SHALL have port rd_en, input, 1: read request.
REQ-011 SHALL have port dout, output, WIDTH: registered read data.
REQ-012 SHALL have port dout_valid, output, 1: one-cycle pulse marking dout as new data.
REQ-013 SHALL have port full, empty, almost_full, almost_empty, output, 1 each: status flags.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow, output, 1 each: sticky error flags.
REQ-016 SHALL have port clr_err, input, 1: clears overflow and underflow.

Function
REQ-017 SHALL accept a write only when wr_en=1 and full=0, storing din at wr_ptr and advancing wr_ptr modulo DEPTH.
REQ-018 SHALL accept a read only when rd_en=1 and empty=0, advancing rd_ptr modulo DEPTH.
REQ-019 SHALL drive dout with the entry read on the clock edge after acceptance (latency 1) and pulse dout_valid for that one cycle.
REQ-020 SHALL hold dout unchanged when no read is accepted.
REQ-021 SHALL make all DEPTH entries usable: full = (level == DEPTH), empty = (level == 0).
REQ-022 SHALL update level as +1 on write only, -1 on read only, and unchanged on simultaneous accepted read and write.
REQ-023 SHALL evaluate full and empty on the registered state at the edge: write while full is rejected even with a same-cycle read; read while empty is rejected even with a same-cycle write.
REQ-024 SHALL set overflow on a rejected write (wr_en=1, full=1) and underflow on a rejected read (rd_en=1, empty=1).
REQ-025 SHALL clear error flags on clr_err; a same-cycle new error takes priority over clr_err, so the flag stays set.
REQ-026 SHALL, on flush, zero both pointers and level and drop any same-cycle write and read.
REQ-027 SHALL leave dout, the error flags and memory contents unchanged on flush, and SHALL drive dout_valid=0 during flush.
REQ-028 SHALL derive almost_full and almost_empty combinationally from level.
REQ-029 SHALL wrap pointers without flag glitches; status is a function of level only.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set pointers=0, level=0, dout=0, dout_valid=0, overflow=0 and underflow=0.
REQ-031 SHALL, after reset, present empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-032 SHALL NOT reset memory contents.
REQ-033 SHALL give rst priority over flush, clr_err, wr_en and rd_en, including mid-stream.

Structure
REQ-034 SHALL place default WIDTH and DEPTH, and the level-width helper constant, in shared package audio_fifo_pkg.
REQ-035 SHALL implement storage as sub-module sample_ram: a simple dual-port RAM with a synchronous write port and a synchronous read port and no reset; the pointer, level and flag logic stays in audio_sample_fifo.

Verification
REQ-036 SHALL cover: reset, then write 0x0001..0x0004, then read 4 -> dout 0x0001..0x0004, each one cycle after its rd_en, with dout_valid pulses; empty=1 at end.
REQ-037 SHALL cover: DEPTH=8, write 8 -> full=1, level=8; 9th write -> rejected, overflow=1; clr_err -> overflow=0.
REQ-038 SHALL cover: empty, rd_en=1 -> no dout_valid, dout held, underflow=1.
REQ-039 SHALL cover: level=8 full, simultaneous wr and rd -> read accepted, write rejected, level=7, overflow=1.
REQ-040 SHALL cover: DEPTH=8, 20 interleaved write/read pairs crossing wrap -> data order preserved, level stays 1.
REQ-041 SHALL cover: level=5, flush plus wr_en same cycle -> level=0, empty=1, dout unchanged; then rst mid-write burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/audio_fifo_pkg.sv
// rtl/audio_fifo_pkg.sv - shared defaults and sizing helpers for the audio sample FIFO
package audio_fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 128;

    // Pointer width; DEPTH is a power of two, so pointers wrap on their own.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Level needs one extra bit so that 0..DEPTH are all representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample storage, synchronous write and read, no reset
module sample_ram
    import audio_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [addr_width(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         re_i,
    input  logic [addr_width(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]             rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - single-clock audio sample FIFO with level, status and sticky error flags
module audio_sample_fifo
    import audio_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              din,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int AW = addr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             dout_valid_q;
    logic             dout_zero_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Status depends on level alone, so pointer wrap can never glitch a flag.
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_acc = wr_en && !full;
            rd_acc = rd_en && !empty;

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase

            // A fresh error outranks clr_err in the same cycle.
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end else if (clr_err) begin
                overflow_d = 1'b0;
            end

            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end else if (clr_err) begin
                underflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_zero_q  <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_zero_q <= 1'b0;
            end
        end
    end

    // While not full, wr_ptr never equals a readable rd_ptr, so no same-address collision.
    sample_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (rd_acc && !rst),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // The RAM has no reset; dout reads as zero until the first accepted read after reset.
    assign dout       = dout_zero_q ? '0 : ram_rdata;
    assign dout_valid = dout_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - self-checking bench for audio_sample_fifo with a queue reference model
module tb_audio_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full, empty, almost_full, almost_empty;
    logic [3:0]       level;
    logic             overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_valid = 0;
    bit               m_ov = 0;
    bit               m_un = 0;

    wire [5:0] stat = {full, empty, almost_full, almost_empty, overflow, underflow};

    always #5 clk = ~clk;

    audio_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    function automatic logic [5:0] exp_stat();
        int n = mq.size();
        return {n == DEPTH, n == 0, n >= DEPTH - 4, n <= 4, m_ov, m_un};
    endfunction

    // Drive one cycle and advance the reference model with the pre-edge state.
    task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r,
                         input bit f, input bit c, input bit rs);
        bit was_full, was_empty;
        wr_en = w; din = d; rd_en = r; flush = f; clr_err = c; rst = rs;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (rs) begin
            mq.delete(); m_dout = '0; m_valid = 0; m_ov = 0; m_un = 0;
        end else if (f) begin
            mq.delete(); m_valid = 0;
        end else begin
            m_valid = 0;
            if (r && !was_empty) begin
                m_dout = mq.pop_front();
                m_valid = 1;
            end
            if (w && !was_full) mq.push_back(d);
            if (w && was_full) m_ov = 1; else if (c) m_ov = 0;
            if (r && was_empty) m_un = 1; else if (c) m_un = 0;
        end
        #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; rst = 0;
    endtask

    task automatic test_reset();
        cycle(0, '0, 0, 0, 0, 1);
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (stat !== 6'b010100) begin failures++; $display("FAIL reset_status got=%b exp=010100", stat); end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 0, 0, 0, 0);
        checks++; if (level !== 4'd4) begin failures++; $display("FAIL basic_level got=%0d exp=4", level); end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, '0, 1, 0, 0, 0);
            checks++; if (dout !== WIDTH'(i) || dout_valid !== 1'b1) begin
                failures++; $display("FAIL basic_read%0d got=%h/%b exp=%h/1", i, dout, dout_valid, WIDTH'(i));
            end
        end
        cycle(0, '0, 0, 0, 0, 0);
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h0004) begin
            failures++; $display("FAIL basic_hold got=%h/%b exp=0004/0", dout, dout_valid);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        cycle(0, '0, 1, 0, 0, 0);
        checks++; if (dout_valid !== 1'b0 || dout !== m_dout) begin
            failures++; $display("FAIL underflow_dout got=%h/%b exp=%h/0", dout, dout_valid, m_dout);
        end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b exp=1", underflow); end
        cycle(0, '0, 0, 0, 1, 0);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL underflow_clr got=%b exp=0", underflow); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1, WIDTH'($urandom), 0, 0, 0, 0);
        checks++; if (full !== 1'b1 || level !== 4'd8) begin
            failures++; $display("FAIL full_level got=%b/%0d exp=1/8", full, level);
        end
        cycle(1, 16'hdead, 0, 0, 0, 0);
        checks++; if (overflow !== 1'b1 || level !== 4'd8) begin
            failures++; $display("FAIL overflow_set got=%b/%0d exp=1/8", overflow, level);
        end
        cycle(1, 16'hbeef, 0, 0, 1, 0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_priority got=%b exp=1", overflow); end
        cycle(0, '0, 0, 0, 1, 0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_simul();
        logic [WIDTH-1:0] head = mq[0];
        cycle(1, 16'h5a5a, 1, 0, 0, 0);
        checks++; if (level !== 4'd7 || overflow !== 1'b1) begin
            failures++; $display("FAIL full_simul got=%0d/%b exp=7/1", level, overflow);
        end
        checks++; if (dout !== head || dout_valid !== 1'b1) begin
            failures++; $display("FAIL full_simul_dout got=%h/%b exp=%h/1", dout, dout_valid, head);
        end
        while (mq.size() != 0) begin
            cycle(0, '0, 1, 0, 0, 0);
            checks++; if (dout !== m_dout) begin failures++; $display("FAIL drain_dout got=%h exp=%h", dout, m_dout); end
        end
        cycle(0, '0, 0, 0, 1, 0);
    endtask

    task automatic test_wrap();
        cycle(1, 16'h1000, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1, WIDTH'(16'h1000 + i), 1, 0, 0, 0);
            checks++; if (dout !== WIDTH'(16'h1000 + i - 1) || dout_valid !== 1'b1 || level !== 4'd1) begin
                failures++; $display("FAIL wrap%0d got=%h/%b/%0d exp=%h/1/1", i, dout, dout_valid, level, WIDTH'(16'h1000 + i - 1));
            end
        end
    endtask

    task automatic test_flush_rst();
        logic [WIDTH-1:0] held;
        for (int i = 0; i < 4; i++) cycle(1, WIDTH'($urandom), 0, 0, 0, 0);
        checks++; if (level !== 4'd5) begin failures++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        held = m_dout;
        cycle(1, 16'h7777, 1, 1, 0, 0);
        checks++; if (level !== 4'd0 || empty !== 1'b1 || dout !== held || dout_valid !== 1'b0) begin
            failures++; $display("FAIL flush got=%0d/%b/%h/%b exp=0/1/%h/0", level, empty, dout, dout_valid, held);
        end
        cycle(1, 16'h0123, 1, 0, 0, 0);
        checks++; if (level !== 4'd1 || overflow !== 1'b0 || underflow !== 1'b1) begin
            failures++; $display("FAIL post_flush got=%0d/%b/%b exp=1/0/1", level, overflow, underflow);
        end
        cycle(1, 16'h0124, 1, 0, 0, 0);
        cycle(1, 16'h0125, 0, 0, 0, 0);
        cycle(1, 16'h0126, 1, 0, 0, 1);
        checks++; if (dout !== 16'h0000 || dout_valid !== 1'b0 || level !== 4'd0 || stat !== 6'b010100) begin
            failures++; $display("FAIL rst_mid got=%h/%b/%0d/%b exp=0000/0/0/010100", dout, dout_valid, level, stat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 55, WIDTH'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
            checks++; if (dout_valid !== m_valid || dout !== m_dout) begin
                failures++; $display("FAIL rand%0d_dout got=%h/%b exp=%h/%b", i, dout, dout_valid, m_dout, m_valid);
            end
            checks++; if (level !== 4'(mq.size()) || stat !== exp_stat()) begin
                failures++; $display("FAIL rand%0d_state got=%0d/%b exp=%0d/%b", i, level, stat, mq.size(), exp_stat());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_full_overflow();
        test_full_simul();
        test_wrap();
        test_flush_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
